regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with hazard scoreboard for the RV32E/RV32I pipeline. Provides NRD combinational read ports, NWR synchronous write ports with optional write-to-read bypass, and a per-register busy scoreboard set at issue and cleared at writeback so decode can detect RAW/WAW hazards. Sits between decode (reads, issue) and writeback (writes, clears).

## Interface
- XLEN, 32, data width in bits
- NREGS, 16, architectural register count (16 for E, 32 for I); register 0 hardwired zero
- NRD, 2, read ports
- NWR, 1, write ports
- BYPASS, 1, 1 = read of a register written in the same cycle returns the write data; 0 = returns the old value
- AW, $clog2(NREGS), derived address width (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NRD x AW  read addresses
- rd_data  out  NRD x XLEN  read data
- rd_busy  out  NRD  scoreboard busy flag of each read address
- wr_en  in  NWR  write strobes
- wr_addr  in  NWR x AW  write addresses
- wr_data  in  NWR x XLEN  write data
- iss_en  in  1  issue strobe: mark iss_addr pending
- iss_addr  in  AW  destination of issued instruction
- any_busy  out  1  OR of all busy bits (drain/flush indicator)

## Operation
- Reset: all registers 1..NREGS-1 cleared to 0, all busy bits cleared; rd_busy = 0 and any_busy = 0 the cycle after reset.
- Register 0: reads return 0 regardless of writes; writes to 0 dropped; busy[0] never set; rd_busy for address 0 always 0.
- Write: each wr_en[i] with nonzero wr_addr[i] updates the register at the rising edge and clears busy[wr_addr[i]].
- Same-address writes on several ports in one cycle: highest port index wins, all clear busy.
- Issue: iss_en with nonzero iss_addr sets busy[iss_addr] at the edge.
- Issue and write to same register in the same cycle: set wins, busy remains 1 (new producer outstanding).
- Read: combinational. BYPASS=1 and an active write port matches rd_addr (nonzero): rd_data = that port's wr_data (highest index on multiple matches) and rd_busy = 0 unless iss_en targets the same address in that cycle (then rd_busy = 1). BYPASS=0: rd_data = stored value, rd_busy = stored busy bit.
- Addresses >= NREGS (when NREGS is not a power of two): reads return 0, writes and issues ignored.
- rst overrides concurrent writes/issues: state after a reset cycle is all zero.

## Timing
- Read latency 0 cycles (combinational from rd_addr, wr_*, iss_* when BYPASS=1).
- Write visible on stored path 1 cycle after the edge; on bypass path same cycle.
- Busy set/clear takes effect at the edge; rd_busy reflects it in the following cycle (except bypass case above).
- No stalls, no backpressure; every strobe is accepted each cycle.

## Structure
- Package regfile_pkg: XLEN default, NREGS_E = 16 / NREGS_I = 32 constants, zero-register index constant.
- Sub-module reg_scoreboard: NREGS busy bits, issue/clear ports, set-over-clear priority, any_busy; regfile_mp instantiates it and owns the data array and bypass mux.

## Test plan
- Reset with random prior contents -> every rd_data = 0, rd_busy = 0, any_busy = 0.
- Write x5 = 0xDEADBEEF, read x5 next cycle -> 0xDEADBEEF; write x0 = 0x1234 -> read x0 = 0.
- BYPASS=1: write x7 = 0xA5A5A5A5 while reading x7 same cycle -> rd_data = 0xA5A5A5A5; BYPASS=0 -> old value.
- Issue x3, next cycle rd_busy = 1, any_busy = 1; write x3 -> following cycle rd_busy = 0, any_busy = 0; issue x3 and write x3 same cycle -> busy stays 1.
- NWR=2, both ports write x9 (0x11, 0x22) -> x9 = 0x22.
- rst asserted in same cycle as write x4 = 0xFF and issue x4 -> x4 = 0, busy cleared; repeat with NREGS=32, NRD=3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file: default width, RV32E/RV32I
// register counts and the hardwired-zero register index.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREGS_E  = 16;
    localparam int NREGS_I  = 32;
    localparam int REG_ZERO = 0;

    // A register can hold state only if it is not x0 and it exists in this configuration.
    function automatic logic addr_writable(input int addr, input int nregs);
        return (addr != REG_ZERO) && (addr < nregs);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared when its result is
// written back. A same-cycle issue beats a clear, because the new producer is still outstanding.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_E,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NWR-1:0]          clr_en,
    input  logic [NWR-1:0][AW-1:0]  clr_addr,
    output logic [NREGS-1:0]        busy,
    output logic                    any_busy
);

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (clr_en[i] && addr_writable(int'(clr_addr[i]), NREGS)) begin
                busy_d[clr_addr[i]] = 1'b0;
            end
        end
        if (iss_en && addr_writable(int'(iss_addr), NREGS)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// busy scoreboard used by decode for RAW/WAW hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_E,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     any_busy
);

    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;

    reg_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_en   (wr_en),
        .clr_addr (wr_addr),
        .busy     (busy),
        .any_busy (any_busy)
    );

    // Ports are applied in ascending order so the highest index wins on a collision.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && addr_writable(int'(wr_addr[i]), NREGS)) begin
                regs_d[wr_addr[i]] = wr_data[i];
            end
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // A bypassed read sees the writer's data; its busy bit is about to clear unless a new producer issues now.
    always_comb begin
        logic hit;
        rd_data = '0;
        rd_busy = '0;
        hit     = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            hit = 1'b0;
            if (addr_writable(int'(rd_addr[p]), NREGS)) begin
                rd_data[p] = regs_q[rd_addr[p]];
                rd_busy[p] = busy[rd_addr[p]];
                if (BYPASS) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (wr_en[i] && (wr_addr[i] == rd_addr[p])) begin
                            rd_data[p] = wr_data[i];
                            hit        = 1'b1;
                        end
                    end
                    if (hit) begin
                        rd_busy[p] = iss_en && (iss_addr == rd_addr[p]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: a default bypassing instance and a non-bypassing
// twin share stimulus; a 32-register, 3-read, 2-write instance is driven separately.
module tb_regfile_mp;

    logic clk;
    logic rst;
    logic c_rst;

    logic [1:0][3:0]  rd_addr;
    logic [1:0][31:0] rd_data_a;
    logic [1:0][31:0] rd_data_b;
    logic [1:0]       rd_busy_a;
    logic [1:0]       rd_busy_b;
    logic [0:0]       wr_en;
    logic [0:0][3:0]  wr_addr;
    logic [0:0][31:0] wr_data;
    logic             iss_en;
    logic [3:0]       iss_addr;
    logic             any_busy_a;
    logic             any_busy_b;

    logic [2:0][4:0]  c_rd_addr;
    logic [2:0][31:0] c_rd_data;
    logic [2:0]       c_rd_busy;
    logic [1:0]       c_wr_en;
    logic [1:0][4:0]  c_wr_addr;
    logic [1:0][31:0] c_wr_data;
    logic             c_iss_en;
    logic [4:0]       c_iss_addr;
    logic             c_any_busy;

    int nAsserts;
    int nFails;

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2), .NWR(1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3), .NWR(2), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst(c_rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .any_busy(c_any_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic ie, input logic [3:0] ia);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        nAsserts   = 0;
        nFails     = 0;
        rst        = 1'b1;
        c_rst      = 1'b1;
        rd_addr    = '0;
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        c_rd_addr  = '0;
        c_wr_en    = '0;
        c_wr_addr  = '0;
        c_wr_data  = '0;
        c_iss_en   = 1'b0;
        c_iss_addr = '0;
        tick();
        tick();
        rst   = 1'b0;
        c_rst = 1'b0;
        $display("[TB] filling registers with random data and marking all busy");

        for (int a = 1; a < 16; a++) begin
            applyStimulus(1'b1, 4'(a), $urandom | 32'h1, 1'b1, 4'(a));
            tick();
        end
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("prefill any_busy a", 32'(any_busy_a), 32'h1);
        rd_addr[0] = 4'd9;
        settle();
        checkOutput("prefill x9 nonzero a", 32'(rd_data_a[0] != 0), 32'h1);

        rst = 1'b1;
        applyStimulus(1'b1, 4'd4, 32'h0000_00FF, 1'b1, 4'd4);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr[0] = 4'(a);
            rd_addr[1] = 4'(15 - a);
            settle();
            checkOutput($sformatf("reset data a x%0d", a), rd_data_a[0], 32'h0);
            checkOutput($sformatf("reset data a p1 x%0d", 15 - a), rd_data_a[1], 32'h0);
            checkOutput($sformatf("reset busy a x%0d", a), 32'(rd_busy_a[0]), 32'h0);
            checkOutput($sformatf("reset data b x%0d", a), rd_data_b[0], 32'h0);
            checkOutput($sformatf("reset busy b x%0d", a), 32'(rd_busy_b[0]), 32'h0);
        end
        checkOutput("reset any_busy a", 32'(any_busy_a), 32'h0);
        checkOutput("reset any_busy b", 32'(any_busy_b), 32'h0);

        applyStimulus(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        rd_addr[0] = 4'd5;
        settle();
        checkOutput("x5 stored a", rd_data_a[0], 32'hDEAD_BEEF);
        checkOutput("x5 stored b", rd_data_b[0], 32'hDEAD_BEEF);

        rd_addr[0] = 4'd0;
        applyStimulus(1'b1, 4'd0, 32'h0000_1234, 1'b1, 4'd0);
        settle();
        checkOutput("x0 bypass a", rd_data_a[0], 32'h0);
        checkOutput("x0 busy bypass a", 32'(rd_busy_a[0]), 32'h0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x0 stored a", rd_data_a[0], 32'h0);
        checkOutput("x0 stored b", rd_data_b[0], 32'h0);
        checkOutput("x0 issue any_busy a", 32'(any_busy_a), 32'h0);

        rd_addr[1] = 4'd7;
        applyStimulus(1'b1, 4'd7, 32'hA5A5_A5A5, 1'b0, 4'd0);
        settle();
        checkOutput("x7 bypass a", rd_data_a[1], 32'hA5A5_A5A5);
        checkOutput("x7 no bypass b", rd_data_b[1], 32'h0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x7 stored a", rd_data_a[1], 32'hA5A5_A5A5);
        checkOutput("x7 stored b", rd_data_b[1], 32'hA5A5_A5A5);

        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
        tick();
        applyStimulus(1'b1, 4'd7, 32'h0000_005A, 1'b1, 4'd7);
        settle();
        checkOutput("x7 bypass+issue data a", rd_data_a[1], 32'h0000_005A);
        checkOutput("x7 bypass+issue busy a", 32'(rd_busy_a[1]), 32'h1);
        checkOutput("x7 stored busy b", 32'(rd_busy_b[1]), 32'h1);
        checkOutput("x7 old data b", rd_data_b[1], 32'hA5A5_A5A5);
        tick();
        applyStimulus(1'b1, 4'd7, 32'h0000_0077, 1'b0, 4'd0);
        settle();
        checkOutput("x7 bypass clear busy a", 32'(rd_busy_a[1]), 32'h0);
        checkOutput("x7 stored still busy b", 32'(rd_busy_b[1]), 32'h1);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x7 cleared busy b", 32'(rd_busy_b[1]), 32'h0);
        checkOutput("x7 final data b", rd_data_b[1], 32'h0000_0077);

        rd_addr[0] = 4'd3;
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x3 issued busy a", 32'(rd_busy_a[0]), 32'h1);
        checkOutput("x3 issued any_busy a", 32'(any_busy_a), 32'h1);
        checkOutput("x3 issued busy b", 32'(rd_busy_b[0]), 32'h1);
        applyStimulus(1'b1, 4'd3, 32'h0000_0033, 1'b0, 4'd0);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x3 written busy a", 32'(rd_busy_a[0]), 32'h0);
        checkOutput("x3 written any_busy a", 32'(any_busy_a), 32'h0);
        checkOutput("x3 written any_busy b", 32'(any_busy_b), 32'h0);
        applyStimulus(1'b1, 4'd3, 32'h0000_0034, 1'b1, 4'd3);
        tick();
        applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        settle();
        checkOutput("x3 set wins busy a", 32'(rd_busy_a[0]), 32'h1);
        checkOutput("x3 set wins any_busy a", 32'(any_busy_a), 32'h1);
        checkOutput("x3 set wins data a", rd_data_a[0], 32'h0000_0034);

        $display("[TB] wide configuration: 32 registers, 3 reads, 2 writes");
        c_wr_en      = 2'b11;
        c_wr_addr[0] = 5'd9;
        c_wr_addr[1] = 5'd9;
        c_wr_data[0] = 32'h11;
        c_wr_data[1] = 32'h22;
        c_rd_addr[2] = 5'd9;
        settle();
        checkOutput("c x9 bypass two ports", c_rd_data[2], 32'h22);
        tick();
        c_wr_en = 2'b00;
        settle();
        checkOutput("c x9 stored two ports", c_rd_data[2], 32'h22);

        c_wr_en      = 2'b01;
        c_wr_addr[0] = 5'd31;
        c_wr_data[0] = 32'h3131_3131;
        c_iss_en     = 1'b1;
        c_iss_addr   = 5'd25;
        tick();
        c_wr_en      = 2'b00;
        c_iss_en     = 1'b0;
        c_rd_addr[0] = 5'd31;
        c_rd_addr[1] = 5'd25;
        settle();
        checkOutput("c x31 stored", c_rd_data[0], 32'h3131_3131);
        checkOutput("c x25 busy", 32'(c_rd_busy[1]), 32'h1);
        checkOutput("c any_busy set", 32'(c_any_busy), 32'h1);

        c_rst        = 1'b1;
        c_wr_en      = 2'b10;
        c_wr_addr[1] = 5'd4;
        c_wr_data[1] = 32'hFF;
        c_iss_en     = 1'b1;
        c_iss_addr   = 5'd4;
        tick();
        c_rst        = 1'b0;
        c_wr_en      = 2'b00;
        c_iss_en     = 1'b0;
        c_rd_addr[0] = 5'd4;
        c_rd_addr[1] = 5'd9;
        c_rd_addr[2] = 5'd31;
        settle();
        checkOutput("c reset x4 data", c_rd_data[0], 32'h0);
        checkOutput("c reset x4 busy", 32'(c_rd_busy[0]), 32'h0);
        checkOutput("c reset x9 data", c_rd_data[1], 32'h0);
        checkOutput("c reset x31 data", c_rd_data[2], 32'h0);
        checkOutput("c reset any_busy", 32'(c_any_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
